// File: rtl/assem_mem_stream_rx_pkg.sv
// Shared AssemMem definitions for the seed-stream deframer.
// A record is 23 bytes, packed little-endian with the id LSB in byte 0.
package assem_mem_stream_rx_pkg;

    localparam int ASMMEM_W     = 184;
    localparam int ASMMEM_BYTES = ASMMEM_W / 8;

    typedef logic [ASMMEM_W-1:0] AssemMem;

    function automatic AssemMem UnpackAssemMem(input logic [ASMMEM_W-1:0] v);
        return AssemMem'(v);
    endfunction

endpackage

// File: rtl/asm_byte_gearbox.sv
// Byte accumulator: appends up to IN_BYTES per beat and shifts out one
// REC_BYTES record at a time. The top decides when the count is cleared or clamped.
module asm_byte_gearbox #(
    parameter int IN_BYTES  = 4,
    parameter int REC_BYTES = 23,
    parameter int BUF_BYTES = REC_BYTES + IN_BYTES - 1,
    parameter int CW        = $clog2(BUF_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [IN_BYTES*8-1:0]  wr_data_i,
    input  logic [CW-1:0]          wr_n_i,
    input  logic                   clr_i,
    input  logic                   clamp_i,
    input  logic                   shift_i,
    output logic [CW-1:0]          cnt_o,
    output logic [REC_BYTES*8-1:0] rec_o
);

    logic [BUF_BYTES-1:0][7:0] buf_q, buf_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (shift_i) begin
            // Bytes above the carried remainder are stale but never counted.
            for (int i = 0; i < BUF_BYTES - REC_BYTES; i++)
                buf_d[i] = buf_q[i + REC_BYTES];
            cnt_d = cnt_q - CW'(REC_BYTES);
        end else if (wr_en_i) begin
            for (int k = 0; k < IN_BYTES; k++)
                if ((CW'(k) < wr_n_i) && ((cnt_q + CW'(k)) < CW'(BUF_BYTES)))
                    buf_d[cnt_q + CW'(k)] = wr_data_i[8*k +: 8];
            if (clr_i)
                cnt_d = '0;
            else if (clamp_i)
                cnt_d = CW'(REC_BYTES);
            else
                cnt_d = cnt_q + wr_n_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign rec_o = buf_q[REC_BYTES-1:0];

endmodule

// File: rtl/assem_mem_stream_rx.sv
// AXI4-Stream to AssemMem deframer: tlast resolution, error pulses,
// output handshake and record counter around the byte gearbox.
module assem_mem_stream_rx
    import assem_mem_stream_rx_pkg::*;
#(
    parameter int IN_BYTES  = 4,
    parameter int REC_BYTES = ASMMEM_BYTES,
    parameter int BUF_BYTES = REC_BYTES + IN_BYTES - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_BYTES*8-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic [IN_BYTES-1:0]   s_tkeep,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output AssemMem               m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  err_misalign,
    output logic                  err_keep,
    output logic [31:0]           rec_count
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    logic [CW-1:0]           cnt, keep_n;
    logic [IN_BYTES-1:0]     keep_mask;
    logic                    keep_run;
    logic [CW:0]             c_new;
    logic                    accept, emit, tl, clr, clamp;
    logic [REC_BYTES*8-1:0]  rec;
    logic                    last_flg_q, last_flg_d;
    logic                    err_mis_q, err_mis_d, err_keep_q, err_keep_d;
    logic [31:0]             rec_count_q, rec_count_d;

    // Only the leading run of enabled bytes is appended.
    always_comb begin
        keep_n    = '0;
        keep_mask = '0;
        keep_run  = 1'b1;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (keep_run && s_tkeep[k]) begin
                keep_n       = keep_n + 1'b1;
                keep_mask[k] = 1'b1;
            end else begin
                keep_run = 1'b0;
            end
        end
    end

    assign s_tready = (cnt < CW'(REC_BYTES));
    assign m_valid  = ~s_tready;
    assign accept   = s_tvalid & s_tready;
    assign emit     = m_valid & m_ready;
    assign c_new    = {1'b0, cnt} + {1'b0, keep_n};
    assign tl       = accept & s_tlast;
    assign clr      = tl & (c_new != '0) & (c_new < (CW+1)'(REC_BYTES));
    assign clamp    = tl & (c_new >= (CW+1)'(REC_BYTES));

    always_comb begin
        err_mis_d   = clr | (clamp & (c_new != (CW+1)'(REC_BYTES)));
        err_keep_d  = accept & ((s_tkeep != keep_mask) | (~s_tlast & (s_tkeep != '1)));
        last_flg_d  = last_flg_q;
        rec_count_d = rec_count_q;
        if (emit) begin
            last_flg_d  = 1'b0;
            rec_count_d = rec_count_q + 32'd1;
        end else if (clamp) begin
            last_flg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_flg_q  <= 1'b0;
            err_mis_q   <= 1'b0;
            err_keep_q  <= 1'b0;
            rec_count_q <= '0;
        end else begin
            last_flg_q  <= last_flg_d;
            err_mis_q   <= err_mis_d;
            err_keep_q  <= err_keep_d;
            rec_count_q <= rec_count_d;
        end
    end

    asm_byte_gearbox #(
        .IN_BYTES (IN_BYTES),
        .REC_BYTES(REC_BYTES),
        .BUF_BYTES(BUF_BYTES),
        .CW       (CW)
    ) u_gearbox (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (accept),
        .wr_data_i(s_tdata),
        .wr_n_i   (keep_n),
        .clr_i    (clr),
        .clamp_i  (clamp),
        .shift_i  (emit),
        .cnt_o    (cnt),
        .rec_o    (rec)
    );

    assign m_data       = UnpackAssemMem(rec);
    assign m_last       = m_valid & last_flg_q;
    assign err_misalign = err_mis_q;
    assign err_keep     = err_keep_q;
    assign rec_count    = rec_count_q;

endmodule

// File: tb/tb_assem_mem_stream_rx.sv
// Directed + random bench for assem_mem_stream_rx against a byte-queue
// model of the batch/record rules.
module tb_assem_mem_stream_rx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic [3:0]   s_tkeep = '0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [183:0] m_data;
    logic         m_valid, m_last;
    logic         m_ready = 1'b1;
    logic         err_misalign, err_keep;
    logic [31:0]  rec_count;

    assem_mem_stream_rx dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .err_misalign(err_misalign), .err_keep(err_keep), .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [183:0] d; bit last; } rec_t;

    rec_t        expq[$];
    byte unsigned mq[$];
    logic [31:0] exp_cnt = 0;
    int          n_chk = 0, n_fail = 0;
    int          mode = 0;
    bit          acc_done;
    logic [7:0]  nb = 8'h00;

    task automatic chk(input string tag, input logic [183:0] obs, input logic [183:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input bit last);
        rec_t r;
        r.d = '0;
        for (int b = 0; b < 23; b++) r.d[8*b +: 8] = mq.pop_front();
        r.last = last;
        expq.push_back(r);
    endtask

    // Reference: bytes form one ordered stream; records are carved off 23 at a time,
    // and tlast settles whatever is pending.
    task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input bit l,
                                output bit ek, output bit em);
        int  n;
        logic [3:0] full;
        n = 0;
        for (int i = 0; i < 4; i++) if (k[i] && n == i) n++;
        full = 4'((1 << n) - 1);
        ek = (k != full) || (!l && k != 4'hF);
        em = 1'b0;
        for (int i = 0; i < n; i++) mq.push_back(d[8*i +: 8]);
        if (l) begin
            if (mq.size() != 0 && mq.size() < 23) begin
                em = 1'b1;
                mq.delete();
            end else if (mq.size() >= 23) begin
                em = (mq.size() != 23);
                push_rec(1'b1);
                mq.delete();
            end
        end else if (mq.size() >= 23) begin
            push_rec(1'b0);
        end
    endtask

    task automatic step();
        bit acc, emit, ek, em;
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        ek = 1'b0;
        em = 1'b0;
        acc  = s_tvalid && (expq.size() == 0);
        emit = (expq.size() != 0) && m_ready;
        chk("s_tready", s_tready, expq.size() == 0);
        chk("m_valid", m_valid, expq.size() != 0);
        if (expq.size() != 0) begin
            chk("m_data", m_data, expq[0].d);
            chk("m_last", m_last, expq[0].last);
        end else begin
            chk("m_last_idle", m_last, 1'b0);
        end
        if (emit) begin
            void'(expq.pop_front());
            exp_cnt++;
        end
        if (acc) model_accept(s_tdata, s_tkeep, s_tlast, ek, em);
        acc_done = acc;
        @(posedge clk);
        #1;
        chk("err_keep", err_keep, ek);
        chk("err_misalign", err_misalign, em);
        chk("rec_count", rec_count, exp_cnt);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input bit l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        acc_done = 1'b0;
        for (int i = 0; i < 100 && !acc_done; i++) step();
        if (!acc_done) begin
            n_fail++;
            $error("FAIL accept_timeout observed=stalled expected=accepted");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_bytes(input int len, input bit last, input bit rnd);
        logic [31:0] d;
        int nbt;
        if (len == 0) begin
            send(32'h0, 4'h0, last);
            return;
        end
        for (int pos = 0; pos < len; pos += 4) begin
            nbt = (len - pos < 4) ? len - pos : 4;
            for (int i = 0; i < 4; i++) begin
                d[8*i +: 8] = rnd ? 8'($urandom) : nb;
                if (!rnd) nb = nb + 8'd1;
            end
            if (rnd && $urandom_range(0, 3) == 0) step();
            send(d, 4'((1 << nbt) - 1), last && (pos + 4 >= len));
        end
    endtask

    task automatic drain();
        int m;
        m = mode;
        mode = 0;
        for (int i = 0; i < 200 && expq.size() != 0; i++) step();
        if (expq.size() != 0) begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", expq.size());
        end
        step();
        mode = m;
    endtask

    initial begin
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_err_mis", err_misalign, 1'b0);
        chk("rst_err_keep", err_keep, 1'b0);
        chk("rst_rec_count", rec_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // 24 bytes with tlast: one last record, excess byte dropped
        nb = 8'h00;
        send_bytes(24, 1'b1, 1'b0);
        drain();
        chk("t1_rec_count", rec_count, 32'd1);

        // 92 bytes without tlast: four back-to-back records
        nb = 8'h00;
        send_bytes(92, 1'b0, 1'b0);
        drain();

        // 46 bytes with tlast on a partial beat, then an exact 23-byte batch
        send_bytes(46, 1'b1, 1'b0);
        drain();
        send_bytes(23, 1'b1, 1'b0);
        drain();

        // Downstream stall holds the record and blocks input
        mode = 2;
        send_bytes(23, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step();
        mode = 0;
        step();
        step();

        // Non-contiguous keep on a non-last beat, then reset mid-batch (17 bytes held)
        send_bytes(16, 1'b0, 1'b0);
        send(32'hA4A3A2A1, 4'b0101, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", m_valid, 1'b0);
        chk("mid_rst_s_tready", s_tready, 1'b1);
        chk("mid_rst_rec_count", rec_count, 32'd0);
        mq.delete();
        expq.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bytes(23, 1'b1, 1'b0);
        drain();

        // Random batches of random length and random downstream backpressure
        mode = 1;
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(0, 5) == 0 ? $urandom_range(0, 30) : 23 * $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) len = len + $urandom_range(1, 3);
            send_bytes(len, 1'b1, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
